// File: rtl/id_ex_pipe_stage.sv
// ID/EX pipeline stage: decodes an RV32I instruction word into register
// indices, hazard qualifiers and a sign-extended immediate. It holds the
// result in an output entry, with an optional skid entry, behind a
// valid/ready handshake. It also counts cycles in which execute was
// starved of work.
module id_ex_pipe_stage #(
  parameter int XLEN    = 32,
  parameter int PC_W    = 32,
  parameter int SKID_EN = 1,
  parameter int CNT_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_instr,
  input  logic [PC_W-1:0]   in_pc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PC_W-1:0]   out_pc,
  output logic [6:0]        out_opcode,
  output logic [2:0]        out_funct3,
  output logic [6:0]        out_funct7,
  output logic [4:0]        out_rs1,
  output logic [4:0]        out_rs2,
  output logic [4:0]        out_rd,
  output logic              out_uses_rs1,
  output logic              out_uses_rs2,
  output logic              out_writes_rd,
  output logic [XLEN-1:0]   out_imm,
  output logic [CNT_W-1:0]  bubble_cnt
);

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  // One entry: pc, opcode, funct3, funct7, rs1, rs2, rd, 3 qualifiers, imm.
  localparam int EW = PC_W + 7 + 3 + 7 + 15 + 3 + XLEN;

  typedef enum logic [1:0] {ST_EMPTY, ST_ONE, ST_TWO} state_e;

  state_e          state_q, state_d;
  logic [EW-1:0]   out_q, out_d;
  logic [EW-1:0]   skd_q, skd_d;
  logic            in_ready_q, in_ready_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [EW-1:0]   dec;
  logic            accept;

  // Combinational decode of the incoming word into a packed entry.
  always_comb begin
    logic [6:0]  opc;
    logic [31:0] imm32;
    logic        known, u1, u2, wr;
    opc   = in_instr[6:0];
    imm32 = '0;
    known = 1'b1;
    case (opc)
      OPC_LOAD, OPC_OPIMM, OPC_JALR:
        imm32 = {{20{in_instr[31]}}, in_instr[31:20]};
      OPC_STORE:
        imm32 = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
      OPC_BRANCH:
        imm32 = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                 in_instr[30:25], in_instr[11:8], 1'b0};
      OPC_LUI, OPC_AUIPC:
        imm32 = {in_instr[31:12], 12'b0};
      OPC_JAL:
        imm32 = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                 in_instr[20], in_instr[30:21], 1'b0};
      OPC_OP:
        imm32 = '0;
      default: begin
        imm32 = '0;
        known = 1'b0;
      end
    endcase
    u1  = known && (opc != OPC_LUI) && (opc != OPC_AUIPC) && (opc != OPC_JAL);
    u2  = (opc == OPC_OP) || (opc == OPC_STORE) || (opc == OPC_BRANCH);
    wr  = known && (opc != OPC_STORE) && (opc != OPC_BRANCH) && (in_instr[11:7] != 5'd0);
    dec = {in_pc, opc, in_instr[14:12], in_instr[31:25],
           u1 ? in_instr[19:15] : 5'd0,
           u2 ? in_instr[24:20] : 5'd0,
           wr ? in_instr[11:7]  : 5'd0,
           u1, u2, wr,
           {{(XLEN-31){imm32[31]}}, imm32[30:0]}};
  end

  assign in_ready  = (SKID_EN != 0) ? in_ready_q : ((state_q == ST_EMPTY) || out_ready);
  assign accept    = in_valid && in_ready;
  assign out_valid = (state_q != ST_EMPTY);

  assign {out_pc, out_opcode, out_funct3, out_funct7, out_rs1, out_rs2, out_rd,
          out_uses_rs1, out_uses_rs2, out_writes_rd, out_imm} = out_q;
  assign bubble_cnt = cnt_q;

  // Next-state and entry movement; flush overrides the occupancy outcome.
  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    skd_d   = skd_q;
    case (state_q)
      ST_EMPTY: begin
        if (accept) begin
          state_d = ST_ONE;
          out_d   = dec;
        end
      end
      ST_ONE: begin
        if (accept && out_ready) begin
          out_d = dec;
        end else if (accept) begin
          state_d = ST_TWO;
          skd_d   = dec;
        end else if (out_ready) begin
          state_d = ST_EMPTY;
        end
      end
      ST_TWO: begin
        if (out_ready) begin
          state_d = ST_ONE;
          out_d   = skd_q;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
    if (flush) state_d = ST_EMPTY;
    in_ready_d = (state_d != ST_TWO);
  end

  // Starvation counter: execute ready but nothing to give it; saturates.
  always_comb begin
    cnt_d = cnt_q;
    if (out_ready && !out_valid && !flush && !(&cnt_q))
      cnt_d = cnt_q + CNT_W'(1);
  end

  // State, entries and counter registers; reset clears everything.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_EMPTY;
      out_q      <= '0;
      skd_q      <= '0;
      in_ready_q <= 1'b1;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      out_q      <= out_d;
      skd_q      <= skd_d;
      in_ready_q <= in_ready_d;
      cnt_q      <= cnt_d;
    end
  end

endmodule

// File: doc/id_ex_pipe_stage.md
# id_ex_pipe_stage

Parametrised ID/EX pipeline stage with valid/ready handshake, flush, optional skid buffer and registered decode. It sits between the instruction-fetch/decode boundary and the execute stage. It accepts a raw 32-bit RV32I instruction word plus PC, decodes register indices, control fields and the sign-extended immediate, and registers them. It can back-pressure the front end when execute stalls. A saturating counter records execute-starvation cycles for performance monitoring.

## Interface
Parameters:
- XLEN, 32: immediate width; must be ≥ 32; immediates sign-extended from bit 31.
- PC_W, 32: PC width.
- SKID_EN, 1: 1 = two-entry (output + skid) buffering with registered in_ready; 0 = single entry, combinational in_ready.
- CNT_W, 16: bubble counter width.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  asynchronous active-high reset.
- flush  in  1  kill all held and incoming instructions this cycle.
- in_valid  in  1  upstream instruction present.
- in_ready  out  1  stage can accept this cycle.
- in_instr  in  32  instruction word.
- in_pc  in  PC_W  instruction PC.
- out_valid  out  1  execute-side entry valid.
- out_ready  in  1  execute consumes this cycle.
- out_pc  out  PC_W  PC of the output entry.
- out_opcode  out  7  instr[6:0].
- out_funct3  out  3  instr[14:12].
- out_funct7  out  7  instr[31:25].
- out_rs1, out_rs2, out_rd  out  5 each  register indices; forced to 0 when unused.
- out_uses_rs1, out_uses_rs2, out_writes_rd  out  1 each  hazard qualifiers.
- out_imm  out  XLEN  decoded immediate.
- bubble_cnt  out  CNT_W  saturating starvation count.

## Operation
- Decode is combinational on in_instr and registered on accept (in_valid && in_ready).
- Immediate selection by opcode:
  - I-type (0000011, 0010011, 1100111): instr[31:20].
  - S-type (0100011): {instr[31:25], instr[11:7]}.
  - B-type (1100011): {instr[31], instr[7], instr[30:25], instr[11:8], 0}.
  - U-type (0110111, 0010111): {instr[31:12], 12'b0}.
  - J-type (1101111): {instr[31], instr[19:12], instr[20], instr[30:21], 0}.
  - Any other opcode: 0.
  - All immediates are sign-extended to XLEN.
- uses_rs1 = 0 for LUI, AUIPC, JAL and unknown opcodes; 1 otherwise.
- uses_rs2 = 1 only for OP (0110011), STORE and BRANCH.
- writes_rd = 1 for a known opcode that is not STORE or BRANCH and has rd ≠ 0.
- An index whose qualifier is 0 is output as 0.
- Entries: output register (OUT), plus skid register (SKD) when SKID_EN=1. Order is preserved: SKD is always younger than OUT.
- States (SKID_EN=1):
  - EMPTY (OUT empty, SKD empty): accept → ONE.
  - ONE (OUT full, SKD empty):
    - accept && out_ready → ONE, new data in OUT.
    - accept && !out_ready → TWO, new data in SKD.
    - !accept && out_ready → EMPTY.
  - TWO (OUT full, SKD full): in_ready = 0; out_ready → SKD moves to OUT, state ONE.
- SKID_EN=1: in_ready = !skd_valid, driven from a flop.
- SKID_EN=0: in_ready = !out_valid || out_ready, combinational; TWO is unreachable.
- Flush has priority over every other event:
  - Next cycle out_valid = 0 and skd_valid = 0.
  - An instruction handshaked in the flush cycle is dropped.
  - Data fields need not be cleared.
- bubble_cnt increments when out_ready && !out_valid && !flush. It saturates at all-ones and does not wrap.

## Timing
- Latency: accept at edge N → out_valid and decoded fields at edge N, visible in cycle N+1.
- Throughput: 1 instruction/cycle while out_ready = 1.
- Data stability: while out_valid && !out_ready, all out_* fields stay stable.
- in_ready timing (SKID_EN=1): in_ready falls the cycle after a stall captures into SKD, and rises the cycle after SKD drains.
- Reset (asynchronous, immediate): all outputs 0, except in_ready = 1 when SKID_EN=1 (0 during reset for SKID_EN=0 is not required; in_ready = 1 also applies there since out_valid = 0). This covers out_valid, skd_valid, every field and bubble_cnt.
- Reset mid-operation discards all entries with no partial state.
- Flush together with accept and out_ready in one cycle: the output is consumed (execute already took it), the input is dropped, and the next state is EMPTY.

## Test plan
- Reset release, then ADDI x5,x6,-1 (0xFFF30293) at PC 0x100 → one cycle later:
  - out_valid = 1, out_rd = 5, out_rs1 = 6, out_rs2 = 0, uses_rs2 = 0.
  - out_imm = 0xFFFFFFFF, out_pc = 0x100.
- Immediate decode:
  - SW x2,-4(x1) (0xFE20AE23) → imm = 0xFFFFFFFC, writes_rd = 0, rs2 = 2.
  - BEQ with B-imm -8 → 0xFFFFFFF8.
  - LUI 0x12345 → 0x12345000, uses_rs1 = 0, rs1 = 0.
  - JAL +2048 → 0x00000800.
- Back-pressure (SKID_EN=1): stream of 4 instructions, out_ready held 0 from cycle 2 for 3 cycles →
  - in_ready falls after the second accept.
  - No loss or duplication; outputs appear in order once out_ready returns.
  - out fields stay stable throughout the stall.
- Flush while in TWO, with in_valid = 1 the same cycle → next cycle out_valid = 0 and in_ready = 1; the flushed and incoming PCs never appear.
- bubble_cnt with CNT_W = 3, out_ready = 1, no input for 10 cycles → counts 1..7, then holds at 7.
- SKID_EN=0, out_valid = 1, out_ready = 0 → in_ready = 0 in the same cycle; with out_ready = 1 a simultaneous accept replaces OUT with no bubble.
